// File: rtl/demux32_05.sv
// Five-slot 32-bit result distributor: a shared bus word is captured into the slot
// selected by `signal`, with per-slot valid/ack handshake and sticky overrun flags.
module demux32_05 (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  signal,
    input  logic [31:0] data_In,
    input  logic [4:0]  rd_ack,
    output logic [31:0] data_Out_0,
    output logic [31:0] data_Out_1,
    output logic [31:0] data_Out_2,
    output logic [31:0] data_Out_3,
    output logic [31:0] data_Out_4,
    output logic [4:0]  valid,
    output logic [4:0]  overrun,
    output logic        sel_error
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e state_q [5];
    logic [31:0] data_q  [5];
    logic [4:0]  overrun_q;
    logic        sel_error_q;
    logic [4:0]  wr_hit_d;
    logic        sel_bad_d;

    always_comb begin
        wr_hit_d = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            wr_hit_d[k] = wr_en && (signal == 3'(k));
        end
        sel_bad_d = wr_en && (signal > 3'd4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 5; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            overrun_q   <= '0;
            sel_error_q <= 1'b0;
        end else begin
            sel_error_q <= sel_bad_d;
            for (int unsigned k = 0; k < 5; k++) begin
                unique case (state_q[k])
                    EMPTY: begin
                        if (wr_hit_d[k]) begin
                            state_q[k] <= FULL;
                            data_q[k]  <= data_In;
                        end
                    end
                    FULL: begin
                        // A same-cycle ack consumes the old word, so the overwrite is not an overrun.
                        if (wr_hit_d[k]) begin
                            data_q[k] <= data_In;
                            if (!rd_ack[k]) begin
                                overrun_q[k] <= 1'b1;
                            end
                        end else if (rd_ack[k]) begin
                            state_q[k] <= EMPTY;
                        end
                    end
                    default: state_q[k] <= EMPTY;
                endcase
            end
        end
    end

    always_comb begin
        valid = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            valid[k] = (state_q[k] == FULL);
        end
    end

    assign data_Out_0 = data_q[0];
    assign data_Out_1 = data_q[1];
    assign data_Out_2 = data_q[2];
    assign data_Out_3 = data_q[3];
    assign data_Out_4 = data_q[4];
    assign overrun    = overrun_q;
    assign sel_error  = sel_error_q;

endmodule
